ps2_rx_frame: RTL
=================

# ps2_rx_frame

PS/2 keyboard receive front end: synchronises the raw `ps2_clk`/`ps2_data` pins and deserialises 11-bit device-to-host frames. It strips break sequences, extended prefixes and non-key protocol bytes. Only make scan codes are emitted as a one-cycle `ps2_done` strobe with `ps2_out_data`. It sits directly upstream of the scan-code collection/ASCII conversion stage, which counts `ps2_done` strobes to assemble a 13-key entry.

## Interface
- `TIMEOUT_CYCLES`, default 200000 — system-clock cycles without a `ps2_clk` falling edge, mid-frame, before the frame is aborted (2 ms at 100 MHz).
- `clk` in 1 — system clock; all logic in this domain.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `ps2_clk` in 1 — raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1 — raw PS/2 data pin, asynchronous to `clk`.
- `ps2_done` out 1 — one-cycle strobe: a make scan code is valid on `ps2_out_data`.
- `ps2_out_data` out 8 — last accepted make code; held until the next `ps2_done`.
- `ps2_err` out 1 — one-cycle strobe on frame error (start, stop, parity or timeout).

## Operation
- **Synchroniser:** 2-FF synchroniser on each pin, giving `clk_s` and `dat_s`. A third register `clk_d` holds the previous `clk_s`. `fall = clk_d & ~clk_s`.
- **Sampling:** all sampling happens only on `fall`. Bit order: start(0), D0..D7 (LSB first), odd parity, stop(1).
- **FSM:**
  - `IDLE`: on `fall` with `dat_s=0`, go to `DATA` with bit counter 0. On `fall` with `dat_s=1`, treat as a glitch and stay in `IDLE`; no error is raised.
  - `DATA`: on each `fall`, shift `dat_s` into `shreg[7]` and shift right. After the 8th bit, go to `PARITY`.
  - `PARITY`: on `fall`, latch the parity bit and go to `STOP`.
  - `STOP`: on `fall`, the frame is good iff `dat_s=1` and the parity check passes (see Configuration). Return to `IDLE` either way. A good frame raises an internal `byte_vld` for one cycle. A bad frame pulses `ps2_err`.
- **Timeout:** a 18-bit counter clears on every `fall` and whenever the FSM is in `IDLE`. It increments in every other state. At `TIMEOUT_CYCLES` the FSM goes to `IDLE`, `ps2_err` pulses, and the counter clears.
- **Code filter** (acts on `byte_vld`; flags `brk_pend` and `ext_pend`):
  - `F0` → set `brk_pend`; no output.
  - `E0` → set `ext_pend`; no output.
  - `00`, `FF`, `AA`, `FA`, `EE`, `FE` → discarded; flags unchanged.
  - Any other byte with `brk_pend=1` → discarded (key release); clear both flags.
  - Otherwise → `ps2_out_data <= byte`, `ps2_done` pulses, clear `ext_pend`.
  - Extended make codes are therefore emitted without their prefix, e.g. `E0 5A` gives `5A`.
- **Flags on error:** any `ps2_err` clears `brk_pend` and `ext_pend`.
- **Reset values:** `ps2_done=0`, `ps2_err=0`, `ps2_out_data=8'h00`. FSM in `IDLE`, flags 0, counters 0, synchroniser registers 1 (bus idle high).
- **Reset mid-frame:** partial frame discarded; no strobe is emitted after release.

## Timing
- Pin-to-`fall` latency: 3 `clk` cycles (2 synchroniser stages plus the edge register).
- `byte_vld` is registered in the cycle after the stop-bit `fall`. `ps2_done` and `ps2_out_data` register one cycle after that. End-to-end latency from the stop-bit pin falling edge to `ps2_done` is 5 cycles.
- `ps2_err` for a start/stop/parity error follows the same timing as `ps2_done`, or follows the timeout cycle + 1.
- `ps2_done` and `ps2_err` are never high in the same cycle.
- At least 1 cycle separates consecutive `ps2_done` pulses; in practice the gap is ≥1 frame.
- No backpressure: the downstream stage must accept every strobe.
- Supported `ps2_clk` range is 10–16.7 kHz. `clk` must be ≥ 1 MHz.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the frame is good only if D0..D7 plus the parity bit contains an odd number of 1s. Otherwise the frame is rejected with `ps2_err`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled but ignored. Only start, stop and timeout can produce `ps2_err`.

## Test plan
- **Plain make code:** frame `16` with correct parity (parity bit 0), `ps2_clk` at 12.5 kHz → one `ps2_done` with `ps2_out_data=16`, 5 cycles after the stop-bit falling edge; `ps2_err` stays 0.
- **Break filtering:** send `1E`, `F0`, `1E` → exactly one `ps2_done` with data `1E`; the second `1E` produces nothing.
- **Extended and protocol bytes:** send `E0 5A`, then `AA`, then `E0 F0 5A` → one `ps2_done` with `5A`; nothing for `AA` or the release.
- **Parity error:** frame `45` with parity bit forced to 1 → with `PS2_PARITY_CHECK_EN`, one `ps2_err` and no `ps2_done`; without it, `ps2_done` with data `45`.
- **Timeout then recovery:** with `TIMEOUT_CYCLES=1000`, stop `ps2_clk` after 4 data bits for 1000 cycles → one `ps2_err`, FSM in `IDLE`; a subsequent clean `70` frame → `ps2_done` with data `70`.
- **Reset mid-frame:** assert `rst_n=0` after 6 bits of frame `46`, then release → all outputs at reset values; the remainder of the frame produces no strobe, and the next full `46` frame gives `ps2_done` with data `46`.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: sync pins, deserialise 11-bit frames, emit make codes only (build option PS2_PARITY_CHECK_EN).
// Latency: stop-bit pin fall to ps2_done is 5 clk cycles; ps2_err follows the same pipeline (or timeout + 1).
// Backpressure: none, every ps2_done/ps2_err strobe must be taken by the downstream stage.
module ps2_rx_frame #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_done,
    output logic [7:0] ps2_out_data,
    output logic       ps2_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [17:0] TIMEOUT_LIM = 18'(TIMEOUT_CYCLES);

    logic       clk_s1_q, clk_s_q, clk_d_q, fall_q;
    logic       dat_s1_q, dat_s_q;
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [17:0] to_cnt_q;
    logic       byte_vld_q, frame_err_q;
    logic       brk_pend_q, ext_pend_q, brk_pend_d, ext_pend_d;
    logic       done_q, done_d, err_q;
    logic [7:0] out_q, out_d;
    logic       frame_ok_d;

    // Edge detect is registered, so fall_q lands 3 cycles after the pin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s_q  <= 1'b1;
            clk_d_q  <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s_q  <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s_q  <= clk_s1_q;
            clk_d_q  <= clk_s_q;
            dat_s1_q <= ps2_data;
            dat_s_q  <= dat_s1_q;
            fall_q   <= clk_d_q & ~clk_s_q;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (fall_q && state_q == PARITY) begin
            par_q <= dat_s_q;
        end
    end

    always_comb begin
        frame_ok_d = dat_s_q & (^{shreg_q, par_q});
    end
`else
    always_comb begin
        frame_ok_d = dat_s_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            to_cnt_q    <= 18'd0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != IDLE && to_cnt_q == TIMEOUT_LIM) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                to_cnt_q    <= 18'd0;
            end else if (fall_q) begin
                to_cnt_q <= 18'd0;
                case (state_q)
                    IDLE: begin
                        // A high start bit is a line glitch, silently ignored.
                        if (!dat_s_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg_q   <= {dat_s_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q     <= IDLE;
                        byte_vld_q  <= frame_ok_d;
                        frame_err_q <= ~frame_ok_d;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q == IDLE) begin
                to_cnt_q <= 18'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 18'd1;
            end
        end
    end

    // Scan-code filter: shreg_q is stable while byte_vld_q is high.
    always_comb begin
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        done_d     = 1'b0;
        out_d      = out_q;
        if (frame_err_q) begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end else if (byte_vld_q) begin
            case (shreg_q)
                8'hF0: brk_pend_d = 1'b1;
                8'hE0: ext_pend_d = 1'b1;
                8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                default: begin
                    if (brk_pend_q) begin
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end else begin
                        out_d      = shreg_q;
                        done_d     = 1'b1;
                        ext_pend_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            out_q      <= 8'h00;
        end else begin
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            done_q     <= done_d;
            err_q      <= frame_err_q;
            out_q      <= out_d;
        end
    end

    assign ps2_done     = done_q;
    assign ps2_err      = err_q;
    assign ps2_out_data = out_q;

endmodule
